// File: rtl/fir_pkg.sv
// Shared types and default sizes for the FIR stream controller slice.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } fir_state_t;

    localparam int N2_DEF       = 16;
    localparam int N3_DEF       = 32;
    localparam int TAPS_DEF     = 8;
    localparam int FIR_LAT_DEF  = 1;
    localparam int IN_DEPTH_DEF = 4;

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// Sample-in / result-out valid-ready streams of the FIR stream controller.
// slave: controller side; master: producer/consumer side.
interface fir_stream_ctrl_if
    import fir_pkg::*;
#(
    parameter int N2 = N2_DEF,
    parameter int N3 = N3_DEF
) ();
    logic [N2-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [N3-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational read data at the head.
// Push while full is honoured only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage write, no reset needed since data is only read when non-empty
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/fir_stream_ctrl.sv
// Frame sequencer in front of an external fir_filter: flushes the delay line
// with zeros, streams frame samples through it and buffers results.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; frame_len captured on accepted start
// ST_FLUSH | TAPS cycles of zero input to clear filter history
// ST_RUN   | issuing FIFO samples to the filter under output back-pressure
// ST_DRAIN | all samples issued, waiting for the last results to leave
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int N2       = N2_DEF,
    parameter int N3       = N3_DEF,
    parameter int TAPS     = TAPS_DEF,
    parameter int FIR_LAT  = FIR_LAT_DEF,
    parameter int IN_DEPTH = IN_DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        frame_len,
    fir_stream_ctrl_if.slave  st,
    output logic              busy,
    output logic              done,
    output logic [N2-1:0]     fir_input_data,
    output logic              fir_enable,
    input  logic [N3-1:0]     fir_output_data
);
    localparam int CW = $clog2(IN_DEPTH) + 1;

    fir_state_t       state;
    fir_state_t       state_nxt;
    logic [7:0]       len_q;
    logic [7:0]       iss_cnt;
    logic [7:0]       dlv_cnt;
    logic [7:0]       flush_cnt;
    logic [N2-1:0]    last_q;
    logic [FIR_LAT-1:0] vld_sr;
    logic [1:0]       infl_cnt;
    logic [1:0]       ob_cnt;
    logic [N3-1:0]    ob0;
    logic [N3-1:0]    ob1;

    logic             fifo_full;
    logic             fifo_empty;
    logic [N2-1:0]    fifo_rdata;
    logic [CW-1:0]    fifo_count;

    logic             in_rdy;
    logic             room;
    logic             push;
    logic             issue;
    logic             capture;
    logic             pop_out;
    logic             start_ok;
    logic             start_zero;

    // accepted samples are either still queued or already issued
    assign room       = !fifo_full && (({1'b0, iss_cnt} + 9'(fifo_count)) < {1'b0, len_q});
    assign push       = st.in_valid && in_rdy;
    assign capture    = vld_sr[FIR_LAT-1];
    assign pop_out    = (ob_cnt != 2'd0) && st.out_ready;
    assign start_ok   = (state == ST_IDLE) && start && (frame_len != 8'd0);
    assign start_zero = (state == ST_IDLE) && start && (frame_len == 8'd0);

    assign st.in_ready  = in_rdy;
    assign st.out_valid = (ob_cnt != 2'd0);
    assign st.out_data  = ob0;
    assign busy         = (state != ST_IDLE);

    sync_fifo #(
        .WIDTH (N2),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (issue),
        .wdata (st.in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // next state, filter drive and input acceptance
    always_comb begin
        state_nxt      = state;
        fir_enable     = 1'b0;
        fir_input_data = last_q;
        issue          = 1'b0;
        in_rdy         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                fir_enable     = 1'b1;
                fir_input_data = '0;
                in_rdy         = room;
                if (flush_cnt == 8'd0) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                in_rdy = room;
                // at most two results outstanding so the 2-entry buffer never overflows
                if (!fifo_empty && (({1'b0, infl_cnt} + {1'b0, ob_cnt}) < 3'd2)) begin
                    issue          = 1'b1;
                    fir_enable     = 1'b1;
                    fir_input_data = fifo_rdata;
                    if (iss_cnt + 8'd1 == len_q) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dlv_cnt == len_q) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // frame counters, flush down-counter, held filter input and done pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_q     <= '0;
            iss_cnt   <= '0;
            dlv_cnt   <= '0;
            flush_cnt <= '0;
            last_q    <= '0;
            done      <= 1'b0;
        end else begin
            done <= start_zero || ((state == ST_DRAIN) && (dlv_cnt == len_q));
            if (start_ok) begin
                len_q     <= frame_len;
                iss_cnt   <= '0;
                dlv_cnt   <= '0;
                flush_cnt <= 8'(TAPS - 1);
            end
            if (state == ST_FLUSH) begin
                flush_cnt <= flush_cnt - 8'd1;
                last_q    <= '0;
            end
            if (issue) begin
                iss_cnt <= iss_cnt + 8'd1;
                last_q  <= fifo_rdata;
            end
            if (pop_out) dlv_cnt <= dlv_cnt + 8'd1;
        end
    end

    // in-flight tracking: marks which filter outputs belong to real samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_sr   <= '0;
            infl_cnt <= '0;
        end else begin
            vld_sr <= FIR_LAT'({vld_sr, issue});
            case ({issue, capture})
                2'b10:   infl_cnt <= infl_cnt + 2'd1;
                2'b01:   infl_cnt <= infl_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    // 2-entry output buffer, ob0 is always the head
    always_ff @(posedge CLK) begin
        if (RST) begin
            ob_cnt <= '0;
            ob0    <= '0;
            ob1    <= '0;
        end else begin
            case ({capture, pop_out})
                2'b10: begin
                    if (ob_cnt == 2'd0) ob0 <= fir_output_data;
                    else                ob1 <= fir_output_data;
                    ob_cnt <= ob_cnt + 2'd1;
                end
                2'b01: begin
                    ob0    <= ob1;
                    ob_cnt <= ob_cnt - 2'd1;
                end
                2'b11: begin
                    if (ob_cnt == 2'd1) begin
                        ob0 <= fir_output_data;
                    end else begin
                        ob0 <= ob1;
                        ob1 <= fir_output_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl: a registered FIR stub stands in for fir_filter,
// outputs are compared with a direct convolution of the accepted samples.
module tb_fir_stream_ctrl;
    localparam int N2       = 16;
    localparam int N3       = 32;
    localparam int TAPS     = 8;
    localparam int FIR_LAT  = 1;
    localparam int IN_DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    frame_len = 8'd0;
    logic          busy;
    logic          done;
    logic          fir_enable;
    logic [N2-1:0] fir_input_data;
    logic [N3-1:0] fir_output_data;

    fir_stream_ctrl_if #(.N2(N2), .N3(N3)) st ();

    fir_stream_ctrl #(
        .N2(N2), .N3(N3), .TAPS(TAPS), .FIR_LAT(FIR_LAT), .IN_DEPTH(IN_DEPTH)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .start           (start),
        .frame_len       (frame_len),
        .st              (st),
        .busy            (busy),
        .done            (done),
        .fir_input_data  (fir_input_data),
        .fir_enable      (fir_enable),
        .fir_output_data (fir_output_data)
    );

    always #5 CLK = ~CLK;

    // FIR stub: coefficient k+1 on tap k, one cycle of latency
    logic [N2-1:0] hist [TAPS];

    function automatic logic [N3-1:0] stub_sum(input logic [N2-1:0] x);
        logic [N3-1:0] s;
        s = N3'(x);
        for (int k = 1; k < TAPS; k++) s += N3'(k + 1) * N3'(hist[k-1]);
        return s;
    endfunction

    always @(posedge CLK) begin
        if (fir_enable) begin
            fir_output_data <= stub_sum(fir_input_data);
            hist[0] <= fir_input_data;
            for (int k = 1; k < TAPS; k++) hist[k] <= hist[k-1];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int gcyc = 0;

    logic [N2-1:0] smp [$];
    logic [N2-1:0] acc_q [$];
    int  cur_len, n_dlv, n_en, n_done, en_first, en_flush_last, max_occ, busy_cnt;
    int  bad_flush, bad_issue, bad_ready, bad_stable, bad_busy, bad_idle_en;
    logic prev_stall;
    logic [N3-1:0] prev_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // zero-history convolution over the samples accepted in this frame
    function automatic logic [N3-1:0] ref_y(input int n);
        logic [N3-1:0] s;
        s = '0;
        for (int k = 0; k < TAPS; k++)
            if (n - k >= 0) s += N3'(k + 1) * N3'(acc_q[n-k]);
        return s;
    endfunction

    task automatic monitor();
        int issued;
        if (fir_enable) begin
            if (n_en == 0) en_first = gcyc;
            if (n_en == TAPS - 1) en_flush_last = gcyc;
            if (n_en < TAPS) begin
                if (fir_input_data != '0) bad_flush++;
            end else if ((n_en - TAPS) >= acc_q.size() || fir_input_data != acc_q[n_en-TAPS]) begin
                bad_issue++;
            end
            n_en++;
        end
        if (st.in_ready && acc_q.size() >= cur_len) bad_ready++;
        if (st.in_valid && st.in_ready) acc_q.push_back(st.in_data);
        if (prev_stall && (!st.out_valid || st.out_data != prev_data)) bad_stable++;
        if (st.out_valid && st.out_ready) begin
            check_val("out_data", st.out_data, ref_y(n_dlv));
            n_dlv++;
        end
        prev_stall = st.out_valid && !st.out_ready;
        prev_data  = st.out_data;
        issued = (n_en > TAPS) ? n_en - TAPS : 0;
        if (issued - n_dlv > max_occ) max_occ = issued - n_dlv;
        if (done) begin
            n_done++;
            if (busy) bad_busy++;
        end
        if (busy) busy_cnt++;
        if (!busy && fir_enable) bad_idle_en++;
    endtask

    task automatic cyc();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
        gcyc++;
    endtask

    task automatic clear_track(input int len);
        acc_q.delete();
        cur_len = len; n_dlv = 0; n_en = 0; n_done = 0; en_first = 0; en_flush_last = 0;
        max_occ = 0; busy_cnt = 0; bad_flush = 0; bad_issue = 0; bad_ready = 0;
        bad_stable = 0; bad_busy = 0; bad_idle_en = 0; prev_stall = 1'b0; prev_data = '0;
    endtask

    task automatic fill_smp(input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(N2'($urandom));
    endtask

    task automatic start_frame(input int len);
        clear_track(len);
        st.in_valid = 1'b0;
        start = 1'b1;
        frame_len = 8'(len);
        cyc();
        start = 1'b0;
    endtask

    task automatic drive(input int n_offer, input int in_pct, input int out_pct, input bit stall);
        int idx;
        idx = acc_q.size();
        st.in_valid  = (idx < n_offer) && ($urandom_range(99) < in_pct);
        st.in_data   = (idx < smp.size()) ? smp[idx] : '0;
        st.out_ready = !stall && ($urandom_range(99) < out_pct);
    endtask

    task automatic run_frame(input int len, input int n_offer, input int in_pct, input int out_pct,
                             input int stall_at, input int stall_len, input string tag);
        int n;
        bit fin;
        start_frame(len);
        n = 0;
        fin = 1'b0;
        while (!fin && n < 4000) begin
            drive(n_offer, in_pct, out_pct, (n >= stall_at) && (n < stall_at + stall_len));
            start = busy && ($urandom_range(7) == 0);
            frame_len = 8'($urandom);
            cyc();
            fin = (n_done != 0);
            n++;
        end
        start = 1'b0;
        repeat (3) begin
            drive(n_offer, in_pct, 100, 1'b0);
            cyc();
        end
        st.in_valid  = 1'b0;
        st.out_ready = 1'b0;
        check_val({tag, "_done"}, fin, 1);
        check_val({tag, "_accepted"}, acc_q.size(), len);
        check_val({tag, "_delivered"}, n_dlv, len);
        check_val({tag, "_enables"}, n_en, TAPS + len);
        check_val({tag, "_flush_run"}, en_flush_last - en_first, TAPS - 1);
        check_val({tag, "_flush_zero"}, bad_flush, 0);
        check_val({tag, "_issue_order"}, bad_issue, 0);
        check_val({tag, "_in_ready_cap"}, bad_ready, 0);
        check_val({tag, "_out_stable"}, bad_stable, 0);
        check_val({tag, "_done_once"}, n_done, 1);
        check_val({tag, "_done_idle"}, bad_busy, 0);
        check_val({tag, "_busy_end"}, busy, 0);
        check_val({tag, "_idle_enable"}, bad_idle_en, 0);
        if (stall_len > 0) check_val({tag, "_occ_full"}, max_occ, 2);
        else               check_val({tag, "_occ_max"}, max_occ <= 2, 1);
        if (!fin) begin
            RST = 1'b1;
            cyc();
            cyc();
            RST = 1'b0;
        end
    endtask

    initial begin
        st.in_valid  = 1'b0;
        st.in_data   = '0;
        st.out_ready = 1'b0;
        clear_track(0);
        repeat (3) cyc();
        check_val("rst_in_ready", st.in_ready, 0);
        check_val("rst_out_valid", st.out_valid, 0);
        check_val("rst_out_data", st.out_data, 0);
        check_val("rst_fir_enable", fir_enable, 0);
        check_val("rst_fir_input", fir_input_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        RST = 1'b0;
        cyc();

        smp = {16'd1, 16'd2, 16'd3, 16'd4};
        run_frame(4, 4, 100, 100, 0, 0, "basic");

        smp = {16'd1, 16'd2, 16'd3, 16'd4};
        run_frame(4, 4, 100, 100, 9, 10, "stall");

        fill_smp(6);
        run_frame(3, 6, 100, 100, 0, 0, "overoffer");

        start_frame(0);
        check_val("zl_done_next", done, 1);
        check_val("zl_busy", busy, 0);
        cyc();
        check_val("zl_done_pulse", done, 0);
        repeat (3) cyc();
        check_val("zl_done_count", n_done, 1);
        check_val("zl_enables", n_en, 0);
        check_val("zl_busy_seen", busy_cnt, 0);

        fill_smp(4);
        start_frame(4);
        for (int i = 0; i < 30; i++) begin
            drive(4, 100, 0, 1'b1);
            cyc();
        end
        check_val("rst_mid_enables", n_en, TAPS + 2);
        check_val("rst_mid_occ", max_occ, 2);
        check_val("rst_mid_valid", st.out_valid, 1);
        st.in_valid = 1'b0;
        RST = 1'b1;
        cyc();
        check_val("rst_mid_out_valid", st.out_valid, 0);
        check_val("rst_mid_in_ready", st.in_ready, 0);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_fir_enable", fir_enable, 0);
        RST = 1'b0;
        cyc();
        fill_smp(2);
        run_frame(2, 2, 100, 100, 0, 0, "after_rst");

        for (int f = 0; f < 3; f++) begin
            int len;
            len = int'($urandom_range(40, 1));
            fill_smp(len + 3);
            run_frame(len, len + int'($urandom_range(3)), int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 30)), 0, 0, "rand");
        end

        fill_smp(255);
        run_frame(255, 255, 50, 50, 0, 0, "long");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_stream_ctrl.md
FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 Parameter N2, default 16, input sample word width (matches fir_filter input_data).
REQ-002 Parameter N3, default 32, filter output word width (matches fir_filter output_data).
REQ-003 Parameter TAPS, default 8, number of zero samples issued to flush the filter delay line.
REQ-004 Parameter FIR_LAT, default 1, cycles from fir_enable-qualified issue to valid fir_out.
REQ-005 Parameter IN_DEPTH, default 4, input FIFO depth (power of two).
REQ-006 CLK  in  1  sole clock, rising edge.
REQ-007 RST  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  one-cycle frame start request; sampled only in IDLE.
REQ-009 frame_len  in  8  samples in frame, captured on accepted start.
REQ-010 in_data / in_valid / in_ready  in/in/out  N2/1/1  input sample stream, valid/ready.
REQ-011 out_data / out_valid / out_ready  out/out/in  N3/1/1  filtered output stream, valid/ready.
REQ-012 busy / done  out/out  1/1  frame in progress; one-cycle frame-complete pulse.
REQ-013 fir_input_data / fir_enable  out/out  N2/1  drive fir_filter input_data / ENABLE.
REQ-014 fir_output_data  in  N3  from fir_filter output_data.

Function
REQ-015 FSM states IDLE, FLUSH, RUN, DRAIN; encoding in shared package.
REQ-016 IDLE: start=1 with frame_len>0 -> FLUSH, latch frame_len, zero issue and delivery counters; start with frame_len=0 -> done pulse next cycle, stay IDLE.
REQ-017 FLUSH: exactly TAPS consecutive cycles of fir_enable=1, fir_input_data=0; corresponding outputs discarded; then -> RUN.
REQ-018 in_ready=1 iff state is FLUSH or RUN, FIFO not full, and accepted-sample count < frame_len; samples beyond frame_len are never accepted.
REQ-019 Transfer on in_valid&in_ready; FIFO push simultaneous with pop on full FIFO is legal (in_ready reflects pre-pop fullness).
REQ-020 RUN issue condition: FIFO non-empty AND (in-flight + output-buffer occupancy) < 2; on issue pop FIFO, fir_input_data=sample, fir_enable=1 same cycle; otherwise fir_enable=0, fir_input_data holds last value.
REQ-021 Each issued sample's fir_output_data captured exactly FIR_LAT cycles after issue into a 2-entry output buffer, in order.
REQ-022 out_valid=1 iff output buffer non-empty; out_data stable while out_valid&!out_ready; pop on out_valid&out_ready; simultaneous capture and pop on full buffer legal.
REQ-023 RUN -> DRAIN when issued count reaches frame_len; DRAIN -> IDLE with done=1 for one cycle when delivered count = frame_len.
REQ-024 busy=1 in FLUSH, RUN, DRAIN; 0 in IDLE.
REQ-025 start ignored outside IDLE; counters 8-bit, no wrap within frame.

Reset
REQ-026 RST=1 at a rising edge: state IDLE, FIFOs and in-flight pipeline emptied, counters 0, in_ready=0, out_valid=0, out_data=0, fir_enable=0, fir_input_data=0, busy=0, done=0.
REQ-027 RST mid-frame abandons frame; no partial output delivered after reset deasserts.

Structure
REQ-028 Shared package fir_pkg holds state enum, N2/N3 defaults, TAPS default.
REQ-029 Input FIFO is one sub-module, sync_fifo (parameter width, depth; push/pop/full/empty/count).
REQ-030 In-flight tracking is a FIR_LAT-deep valid shift register inside fir_stream_ctrl.

Verification
REQ-031 Start frame_len=4, samples 1,2,3,4 back-to-back, out_ready=1 -> 8 flush enables, then 4 outputs in order, done pulse once, busy low after.
REQ-032 Same frame with out_ready=0 for 10 cycles mid-frame -> at most 2 outputs buffered, fir_enable stalls, out_data stable, no loss, order preserved.
REQ-033 Driver offers 6 samples with frame_len=3 -> exactly 3 accepted, in_ready low thereafter, 3 outputs, done.
REQ-034 start with frame_len=0 -> done pulse one cycle later, busy stays 0, fir_enable stays 0.
REQ-035 RST asserted during RUN with 2 outputs buffered -> next cycle out_valid=0, in_ready=0, state IDLE; new frame_len=2 frame completes correctly.
REQ-036 Random in_valid/out_ready (50%) over frame_len=255 -> 255 outputs matching reference FIR model, zero-flushed history.
